wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares one register-file write port between pipeline writeback (A) and a multi-cycle unit (B)
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              stall_a,
  input  logic              port_we,
  input  logic [DATA_W-1:0] port_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] out_port
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    FORCE  = 2'd1,
    REPLAY = 2'd2
  } state_t;

  // The counter never holds STARVE_LIMIT itself: it clears on the cycle it would reach it.
  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              stall_q;
  logic [DATA_W-1:0] out_q;
  logic              we_c;
  logic              b_ready_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;

  // State, starve counter, hold entry and the registered stall flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      stall_q      <= (state_d != ARB);
    end
  end

  // Next-state, write-port mux and B handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    we_c         = 1'b0;
    b_ready_c    = 1'b0;
    waddr_c      = a_addr;
    wdata_c      = a_data;
    case (state_q)
      ARB: begin
        if (a_valid) begin
          we_c = 1'b1;
          if (b_valid) begin
            if (cnt_q + CNT_W'(1) == LIMIT) begin
              state_d = FORCE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end else if (b_valid) begin
          we_c      = 1'b1;
          waddr_c   = b_addr;
          wdata_c   = b_data;
          b_ready_c = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = '0;
        end
      end
      FORCE: begin
        // A dropped b_valid here means no B write; the slot is still reserved for B.
        we_c      = b_valid;
        waddr_c   = b_addr;
        wdata_c   = b_data;
        b_ready_c = 1'b1;
        cnt_d     = '0;
        if (a_valid) begin
          hold_valid_d = 1'b1;
          hold_addr_d  = a_addr;
          hold_data_d  = a_data;
          state_d      = REPLAY;
        end else begin
          state_d = ARB;
        end
      end
      REPLAY: begin
        // a_valid is ignored here; the pipeline is stalled.
        we_c         = hold_valid_q;
        waddr_c      = hold_addr_q;
        wdata_c      = hold_data_q;
        hold_valid_d = 1'b0;
        cnt_d        = '0;
        state_d      = ARB;
      end
      default: begin
        state_d      = ARB;
        cnt_d        = '0;
        hold_valid_d = 1'b0;
      end
    endcase
  end

  // Output port register, independent of arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (port_we) begin
      out_q <= port_data;
    end
  end

  // Combinational strobes are gated so they read 0 throughout reset.
  assign rf_we    = rst_n & we_c;
  assign b_ready  = rst_n & b_ready_c;
  assign rf_waddr = waddr_c;
  assign rf_wdata = wdata_c;
  assign stall_a  = stall_q;
  assign out_port = out_q;

  // The pipeline must not present a write during the second stall cycle.
  a_valid_in_replay : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == REPLAY) |-> !a_valid);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, port_we;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data, port_data;
  logic        b_ready, stall_a, rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata, out_port;

  logic        a1_valid, b1_valid;
  logic        b1_ready, stall1, rf1_we;
  logic [2:0]  rf1_waddr;
  logic [15:0] rf1_wdata, out1;

  logic [18:0] sb[$];
  logic [18:0] ent;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
    .b_ready(b_ready), .stall_a(stall_a),
    .port_we(port_we), .port_data(port_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_port(out_port)
  );

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_LIMIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a1_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b1_valid), .b_addr(b_addr), .b_data(b_data),
    .b_ready(b1_ready), .stall_a(stall1),
    .port_we(1'b0), .port_data(port_data),
    .rf_we(rf1_we), .rf_waddr(rf1_waddr), .rf_wdata(rf1_wdata),
    .out_port(out1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [15:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  // Checks the current cycle at the falling edge, then advances to just after the next rising edge.
  task automatic step(input string tag, input logic exp_we, input logic exp_br, input logic exp_st);
    @(negedge clk);
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(exp_br));
    chk({tag, ".stall_a"}, 32'(stall_a), 32'(exp_st));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(exp_we));
    if (rf_we === 1'b1 && exp_we) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
        ent = sb.pop_front();
        chk({tag, ".waddr"}, 32'(rf_waddr), 32'(ent[18:16]));
        chk({tag, ".wdata"}, 32'(rf_wdata), 32'(ent[15:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Four blocked cycles leading to FORCE on the fifth, with B held at (ba, bd).
  task automatic starve(input string tag, input logic [2:0] ba, input logic [15:0] bd);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b1, ba, bd);
      sb.push_back({3'(i), 16'hA000 + 16'(i)});
      step(tag, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; port_we = 1'b0; port_data = '0;
    a1_valid = 1'b0; b1_valid = 1'b0;
    drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    #2;
    chk("rst.rf_we", 32'(rf_we), 32'(0));
    chk("rst.b_ready", 32'(b_ready), 32'(0));
    chk("rst.stall_a", 32'(stall_a), 32'(0));
    chk("rst.out_port", 32'(out_port), 32'(0));
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Lone B request goes straight through.
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1234);
    sb.push_back({3'd5, 16'h1234});
    step("b_only", 1'b1, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step("idle0", 1'b0, 1'b0, 1'b0);

    // Starvation -> FORCE with A captured -> REPLAY -> ARB.
    starve("starve", 3'd6, 16'h0B06);
    drive(1'b1, 3'd7, 16'hA004, 1'b1, 3'd6, 16'h0B06);
    sb.push_back({3'd6, 16'h0B06});
    sb.push_back({3'd7, 16'hA004});
    step("force", 1'b1, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step("replay", 1'b1, 1'b0, 1'b1);
    step("arb_back", 1'b0, 1'b0, 1'b0);

    // FORCE with no A: no REPLAY.
    starve("starve2", 3'd4, 16'h0B04);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h0B04);
    sb.push_back({3'd4, 16'h0B04});
    step("force_noa", 1'b1, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step("noreplay", 1'b0, 1'b0, 1'b0);

    // Same address: A first, B on a later cycle.
    drive(1'b1, 3'd3, 16'h00AA, 1'b1, 3'd3, 16'h00BB);
    sb.push_back({3'd3, 16'h00AA});
    step("same_a", 1'b1, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h00BB);
    sb.push_back({3'd3, 16'h00BB});
    step("same_b", 1'b1, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step("idle1", 1'b0, 1'b0, 1'b0);

    // B drops in FORCE: only the captured A is written.
    starve("starve3", 3'd1, 16'h0B01);
    drive(1'b1, 3'd2, 16'h00C2, 1'b0, 3'd1, 16'h0B01);
    sb.push_back({3'd2, 16'h00C2});
    step("force_bdrop", 1'b0, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    step("replay_bdrop", 1'b1, 1'b0, 1'b1);
    step("idle2", 1'b0, 1'b0, 1'b0);

    // Output port load and hold.
    port_we = 1'b1; port_data = 16'hBEEF;
    step("port_load", 1'b0, 1'b0, 1'b0);
    port_we = 1'b0; port_data = 16'h1111;
    chk("out_port.load", 32'(out_port), 32'hBEEF);
    step("port_hold", 1'b0, 1'b0, 1'b0);
    chk("out_port.hold", 32'(out_port), 32'hBEEF);

    // Reset during REPLAY discards the held A.
    starve("starve4", 3'd5, 16'h0B05);
    drive(1'b1, 3'd1, 16'h0DD1, 1'b1, 3'd5, 16'h0B05);
    sb.push_back({3'd5, 16'h0B05});
    step("force_rst", 1'b1, 1'b1, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("replay_rst.stall_pre", 32'(stall_a), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("replay_rst.rf_we", 32'(rf_we), 32'(0));
    chk("replay_rst.stall_a", 32'(stall_a), 32'(0));
    chk("replay_rst.b_ready", 32'(b_ready), 32'(0));
    chk("replay_rst.out_port", 32'(out_port), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst0", 1'b0, 1'b0, 1'b0);
    step("post_rst1", 1'b0, 1'b0, 1'b0);

    // STARVE_LIMIT=1 instance: forced after one blocked cycle.
    a_addr = 3'd6; a_data = 16'h0A06; b_addr = 3'd2; b_data = 16'h0B12;
    a1_valid = 1'b1; b1_valid = 1'b1;
    @(negedge clk);
    chk("lim1.c0.b_ready", 32'(b1_ready), 32'(0));
    chk("lim1.c0.wdata", 32'(rf1_wdata), 32'h0A06);
    @(posedge clk); #1;
    a1_valid = 1'b0;
    @(negedge clk);
    chk("lim1.c1.b_ready", 32'(b1_ready), 32'(1));
    chk("lim1.c1.stall", 32'(stall1), 32'(1));
    chk("lim1.c1.rf_we", 32'(rf1_we), 32'(1));
    chk("lim1.c1.waddr", 32'(rf1_waddr), 32'd2);
    chk("lim1.c1.wdata", 32'(rf1_wdata), 32'h0B12);
    @(posedge clk); #1;
    b1_valid = 1'b0;
    @(negedge clk);
    chk("lim1.c2.stall", 32'(stall1), 32'(0));
    chk("lim1.c2.rf_we", 32'(rf1_we), 32'(0));

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
